uart_tx: RTL and testbench

Byte-serial UART transmitter for the ispMACH 4256ZE breakout board design. It is clocked directly from the 5 MHz `osc_clk` produced by the on-chip oscillator, and derives the bit rate with an internal divider. The block accepts one byte at a time over a valid/ready handshake and shifts it out on `txd` as a standard asynchronous frame: start bit, 8 data bits LSB first, optional parity, one stop bit. It is the first stage of the UART datapath and drives the board's serial output pin.

---
 rtl/uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx -- byte-serial asynchronous UART transmitter.
//
// Frame: start bit (0), 8 data bits LSB first, optional even parity bit,
// one stop bit (1). Each bit lasts CLK_DIV cycles of osc_clk.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> even parity bit after data bit 7 (11-bit frame)
//   undefined -> no parity state/logic (10-bit frame)
//
// Ports:
//   osc_clk   in   sole clock, rising edge
//   nrst      in   asynchronous active-low reset
//   tx_data   in   [7:0] byte to send, sampled on the accept edge
//   tx_valid  in   tx_data is valid
//   tx_ready  out  block can accept a byte (registered)
//   txd       out  serial line, idle high (registered)
//   busy      out  frame in progress (registered)
module uart_tx #(
    parameter int CLK_DIV = 521
) (
    input  logic       osc_clk,
    input  logic       nrst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [2:0]  bit_idx_r, bit_idx_s;
    logic [7:0]  shift_r, shift_s;
    logic        txd_r, txd_s;
    logic        ready_r, ready_s;
    logic        busy_r, busy_s;
`ifdef UART_TX_PARITY_EN
    logic        parity_r, parity_s;
`endif

    // State and output registers; reset parks the line high and abandons any frame.
    always_ff @(posedge osc_clk or negedge nrst) begin
        if (!nrst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            txd_r     <= 1'b1;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            txd_r     <= txd_s;
            ready_r   <= ready_s;
            busy_r    <= busy_s;
`ifdef UART_TX_PARITY_EN
            parity_r  <= parity_s;
`endif
        end
    end

    // Next-state logic. txd_s is the line value for the state being entered,
    // so the registered txd changes on the same edge as the state.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        txd_s     = txd_r;
        ready_s   = ready_r;
        busy_s    = busy_r;
`ifdef UART_TX_PARITY_EN
        parity_s  = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                txd_s   = 1'b1;
                ready_s = 1'b1;
                busy_s  = 1'b0;
                // ready_r (not ready_s) gates accept: first edge after reset only raises ready.
                if (tx_valid && ready_r) begin
                    shift_s   = tx_data;
                    state_s   = ST_START;
                    cnt_s     = RELOAD;
                    bit_idx_s = 3'd0;
                    txd_s     = 1'b0;
                    ready_s   = 1'b0;
                    busy_s    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_s  = even_parity(tx_data);
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r != 16'd0) begin
                    cnt_s = cnt_r - 16'd1;
                end else begin
                    state_s   = ST_DATA;
                    cnt_s     = RELOAD;
                    bit_idx_s = 3'd0;
                    txd_s     = shift_r[0];
                end
            end
            ST_DATA: begin
                if (cnt_r != 16'd0) begin
                    cnt_s = cnt_r - 16'd1;
                end else if (bit_idx_r == 3'd7) begin
                    cnt_s = RELOAD;
`ifdef UART_TX_PARITY_EN
                    state_s = ST_PARITY;
                    txd_s   = parity_r;
`else
                    state_s = ST_STOP;
                    txd_s   = 1'b1;
`endif
                end else begin
                    cnt_s     = RELOAD;
                    bit_idx_s = bit_idx_r + 3'd1;
                    shift_s   = shift_r >> 1;
                    txd_s     = shift_r[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r != 16'd0) begin
                    cnt_s = cnt_r - 16'd1;
                end else begin
                    state_s = ST_STOP;
                    cnt_s   = RELOAD;
                    txd_s   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_r != 16'd0) begin
                    cnt_s = cnt_r - 16'd1;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = 16'd0;
                    txd_s   = 1'b1;
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 16'd0;
                txd_s   = 1'b1;
                ready_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign tx_ready = ready_r;
    assign txd      = txd_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int D  = 4;
    localparam int DD = 521;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, txd, busy;
    logic [7:0] d_data = 8'd0;
    logic       d_valid = 1'b0;
    logic       d_ready, d_txd, d_busy;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int falls_q[$];
    int hi_run = 0;

    always #100 clk = ~clk;

    uart_tx #(.CLK_DIV(D)) dut (
        .osc_clk(clk), .nrst(nrst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .txd(txd), .busy(busy)
    );

    uart_tx dut_def (
        .osc_clk(clk), .nrst(nrst), .tx_data(d_data), .tx_valid(d_valid),
        .tx_ready(d_ready), .txd(d_txd), .busy(d_busy)
    );

    // Length of each high run of txd, recorded when the line falls.
    initial begin
        forever begin
            @(negedge clk);
            if (txd === 1'b1) begin
                hi_run++;
            end else begin
                if (hi_run > 0) falls_q.push_back(hi_run);
                hi_run = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: line bit k of the frame, built from the byte arithmetically.
    function automatic logic [10:0] model_line(input logic [7:0] b);
        logic [10:0] l;
        int ones;
        l = 11'h7FF;
        l[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            l[i + 1] = b[i];
            ones = ones + int'(b[i]);
        end
`ifdef UART_TX_PARITY_EN
        l[9] = ((ones % 2) == 1);
`endif
        l[FB - 1] = 1'b1;
        return l;
    endfunction

    // mode 0: drop valid after accept; 1: hold valid+data; 2: hold valid, random data.
    task automatic run_frame(input logic [7:0] b, input logic [10:0] line, input int mode);
        int t;
        t = 0;
        while (tx_ready !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        check("ready_before_accept", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        if (mode == 0) tx_valid = 1'b0;
        for (int k = 0; k < FB * D; k++) begin
            check($sformatf("txd[%02h] cyc %0d", b, k), txd, line[k / D]);
            check($sformatf("ready_low[%02h] cyc %0d", b, k), tx_ready, 0);
            check($sformatf("busy[%02h] cyc %0d", b, k), busy, 1);
            if (mode == 2) tx_data = 8'($urandom);
            step();
        end
        check($sformatf("ready_rise[%02h]", b), tx_ready, 1);
        check($sformatf("busy_end[%02h]", b), busy, 0);
        check($sformatf("txd_idle[%02h]", b), txd, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line_np;
        logic       par;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        logic [10:0] line;
        logic [7:0]  rx;
        int          lows, match, gap, t;

        vecs[0] = '{data: 8'hA5, line_np: 10'b1101001010, par: 1'b0};
        vecs[1] = '{data: 8'h01, line_np: 10'b1000000010, par: 1'b1};
        vecs[2] = '{data: 8'h3C, line_np: 10'b1001111000, par: 1'b0};
        vecs[3] = '{data: 8'h00, line_np: 10'b1000000000, par: 1'b0};
        vecs[4] = '{data: 8'hFF, line_np: 10'b1111111110, par: 1'b0};
        vecs[5] = '{data: 8'h80, line_np: 10'b1100000000, par: 1'b1};

        // Reset with tx_valid asserted throughout.
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        repeat (3) step();
        check("rst_txd", txd, 1);
        check("rst_ready", tx_ready, 0);
        check("rst_busy", busy, 0);
        nrst = 1'b1;
        step();
        check("release_ready", tx_ready, 1);
        check("release_txd", txd, 1);
        check("release_busy", busy, 0);
        run_frame(8'hC3, model_line(8'hC3), 0);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
`ifdef UART_TX_PARITY_EN
            line = {1'b1, vecs[i].par, vecs[i].line_np[8:0]};
`else
            line = {1'b1, vecs[i].line_np};
`endif
            run_frame(vecs[i].data, line, 0);
            step();
        end

        // Busy ignore: noisy data while busy; next accept takes the value after ready rises.
        run_frame(8'h3C, model_line(8'h3C), 2);
        run_frame(8'h5A, model_line(8'h5A), 0);
        step();

        // Back-to-back with valid held: inter-frame high time is CLK_DIV+1.
        falls_q.delete();
        run_frame(8'h00, model_line(8'h00), 1);
        run_frame(8'hFF, model_line(8'hFF), 1);
        tx_valid = 1'b0;
        check("b2b_fall_count", (falls_q.size() >= 2) ? 1 : 0, 1);
        if (falls_q.size() >= 2) check("b2b_stop_high", falls_q[1], D + 1);
        step();

        // Randomized frames against the model.
        for (int r = 0; r < 12; r++) begin
            logic [7:0] b;
            b = 8'($urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) step();
            run_frame(b, model_line(b), 0);
        end

        // Reset mid-frame: txd goes high at once, nothing resumes afterwards.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (10) step();
        check("midrst_pre_txd", txd, 0);
        #50;
        nrst = 1'b0;
        #1;
        check("midrst_txd", txd, 1);
        check("midrst_ready", tx_ready, 0);
        check("midrst_busy", busy, 0);
        repeat (3) step();
        nrst = 1'b1;
        step();
        check("midrst_release_ready", tx_ready, 1);
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            if (txd !== 1'b1) lows++;
            step();
        end
        check("midrst_no_resume", lows, 0);

        // Default divider, mid-bit receiver.
        d_data  = 8'h55;
        d_valid = 1'b1;
        t = 0;
        while (d_ready !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        check("def_ready", d_ready, 1);
        step();
        d_valid = 1'b0;
        line = model_line(8'h55);
        rx = 8'd0;
        for (int j = 0; j < FB; j++) begin
            match = 0;
            for (int c = 0; c < DD; c++) begin
                if (d_txd === line[j]) match++;
                if (c == DD / 2 && j >= 1 && j <= 8) rx[j - 1] = d_txd;
                step();
            end
            check($sformatf("def_bit_len %0d", j), match, DD);
        end
        check("def_rx_byte", rx, 8'h55);
        check("def_ready_end", d_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
